// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: single-issue sequencer for 16-bit R-type / I-type ALU instructions.
// It accepts one instruction in IDLE and reads Rdest/Rsrc from the register file.
// It drives the ALU from registered operands, captures C and Flags, then writes the
// result back and updates the status flags. One instruction takes 4 cycles.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   instr, instr_valid          instruction offer; instr_ready high only in IDLE
//   rf_raddr_dst/src            register-file read addresses (Rdest, Rsrc)
//   rf_rdata_dst/src            combinational register-file read data
//   alu_opcode/a/b              ALU operation and operands (registered)
//   alu_c, alu_flags            ALU result and flags
//   rf_wen/waddr/wdata          register-file write port (one-cycle strobe)
//   psr_flags                   architectural flag register
//   done, illegal               one-cycle retire / undecodable pulses
//   retired                     count of retired legal instructions (wraps)
module alu_seq_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] rf_raddr_dst,
  output logic [RADDR_W-1:0] rf_raddr_src,
  input  logic [DATA_W-1:0]  rf_rdata_dst,
  input  logic [DATA_W-1:0]  rf_rdata_src,
  output logic [7:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic [4:0]         alu_flags,
  output logic               rf_wen,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [4:0]         psr_flags,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam int unsigned IMM_W = 8;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] instr_q;
  logic [4:0]  flags_q;
  logic        cmp_q;

  logic [3:0]        op_c;
  logic [3:0]        opext_c;
  logic [IMM_W-1:0]  imm_c;
  logic              rtype_c;
  logic              legal_c;
  logic              cmp_c;
  logic              sext_c;
  logic [7:0]        opcode_c;
  logic [DATA_W-1:0] b_c;

  // The six legal function codes are shared by R-type opext and I-type op.
  function automatic logic is_legal_fn(input logic [3:0] f);
    case (f)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB: is_legal_fn = 1'b1;
      default:                            is_legal_fn = 1'b0;
    endcase
  endfunction

  // Decode of the latched instruction; only consumed while in DECODE.
  always_comb begin
    op_c     = instr_q[15:12];
    opext_c  = instr_q[7:4];
    imm_c    = instr_q[7:0];
    rtype_c  = (op_c == 4'h0);
    legal_c  = rtype_c ? is_legal_fn(opext_c) : is_legal_fn(op_c);
    cmp_c    = rtype_c ? (opext_c == 4'hB) : (op_c == 4'hB);
    // Arithmetic immediates (ADDI/SUBI/CMPI) sign-extend; logical ones zero-extend.
    sext_c   = (op_c == 4'h5) || (op_c == 4'h9) || (op_c == 4'hB);
    opcode_c = rtype_c ? {4'b0000, opext_c} : {op_c, 4'b0000};
    if (rtype_c) begin
      b_c = rf_rdata_src;
    end else if (sext_c) begin
      b_c = {{(DATA_W-IMM_W){imm_c[IMM_W-1]}}, imm_c};
    end else begin
      b_c = {{(DATA_W-IMM_W){1'b0}}, imm_c};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (instr_valid) next_state = DECODE;
      DECODE:  next_state = legal_c ? EXEC : IDLE;
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered datapath and outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_ready  <= 1'b1;
      instr_q      <= 16'h0000;
      rf_raddr_dst <= '0;
      rf_raddr_src <= '0;
      alu_opcode   <= 8'h00;
      alu_a        <= '0;
      alu_b        <= '0;
      cmp_q        <= 1'b0;
      flags_q      <= 5'b00000;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      psr_flags    <= 5'b00000;
      done         <= 1'b0;
      illegal      <= 1'b0;
      retired      <= '0;
    end else begin
      rf_wen      <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      // Ready tracks the state the FSM is about to enter, so it is high exactly in IDLE.
      instr_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q      <= instr;
            rf_raddr_dst <= RADDR_W'(instr[11:8]);
            rf_raddr_src <= RADDR_W'(instr[3:0]);
          end
        end
        DECODE: begin
          if (legal_c) begin
            alu_opcode <= opcode_c;
            alu_a      <= rf_rdata_dst;
            alu_b      <= b_c;
            cmp_q      <= cmp_c;
            rf_waddr   <= RADDR_W'(instr_q[11:8]);
          end else begin
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          rf_wdata <= alu_c;
          flags_q  <= alu_flags;
        end
        WB: begin
          // Compares update flags only; the destination register is left untouched.
          rf_wen    <= ~cmp_q;
          done      <= 1'b1;
          psr_flags <= flags_q;
          retired   <= retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
